// File: rtl/adder_arb_pkg.sv
// Shared types, defaults and the round-robin search helper for the adder-sharing arbiter.
// Used by rr_arbiter and adder_share_arbiter.
package adder_arb_pkg;

    localparam int DEF_BUS_WIDTH = 32;
    localparam int DEF_NUM_REQ   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MID   = 2'd1,
        FULL  = 2'd2
    } rsp_state_e;

    // Index of the first valid bit at or after ptr, wrapping modulo num_req (0 if none valid).
    function automatic int rr_next(input int ptr, input logic [15:0] valid, input int num_req);
        int   win;
        int   idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < num_req) begin
                idx = ptr + i;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end else begin
                    idx = idx;
                end
                if (!found && valid[idx[3:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; the carry out of the top bit is dropped.
module ripple_carry_adder #(
    parameter int BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic [BUS_WIDTH-1:0] out
);

    logic carry_s;

    // Bit-serial sum/carry chain from LSB to MSB
    always_comb begin
        carry_s = 1'b0;
        out     = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            out[i]  = in1[i] ^ in2[i] ^ carry_s;
            carry_s = (in1[i] & in2[i]) | (carry_s & (in1[i] ^ in2[i]));
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: valid vector plus search pointer gives a one-hot grant
// and the winner index.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any_valid
);

    logic [15:0] valid_ext_s;

    // Widen the request vector to the helper's fixed 16-bit form
    always_comb begin
        valid_ext_s              = 16'd0;
        valid_ext_s[NUM_REQ-1:0] = valid;
    end

    assign any_valid = |valid;
    assign winner    = ID_WIDTH'(rr_next(int'(ptr), valid_ext_s, NUM_REQ));

    // One-hot grant for the winner, only when somebody is asking
    always_comb begin
        grant = '0;
        if (any_valid) begin
            grant[winner] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple_carry_adder among NUM_REQ requesters with round-robin arbitration and a
// registered, id-tagged response. Define ADDER_ARB_SKID_EN for a 2-entry response FIFO.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in2,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [BUS_WIDTH-1:0]         rsp_sum,
    output logic [ID_WIDTH-1:0]          rsp_id
);

    logic [ID_WIDTH-1:0]  ptr_r;
    logic [ID_WIDTH-1:0]  winner_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic                 any_valid_s;
    logic                 accept_s;
    logic                 transfer_s;
    logic [BUS_WIDTH-1:0] op_a_s [NUM_REQ];
    logic [BUS_WIDTH-1:0] op_b_s [NUM_REQ];
    logic [BUS_WIDTH-1:0] add_a_s;
    logic [BUS_WIDTH-1:0] add_b_s;
    logic [BUS_WIDTH-1:0] add_sum_s;
    rsp_state_e           state_r;
    rsp_state_e           state_next_s;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .winner    (winner_s),
        .any_valid (any_valid_s)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a_s[g] = req_in1[g*BUS_WIDTH +: BUS_WIDTH];
        assign op_b_s[g] = req_in2[g*BUS_WIDTH +: BUS_WIDTH];
    end

    assign add_a_s = op_a_s[winner_s];
    assign add_b_s = op_b_s[winner_s];

    ripple_carry_adder #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_adder (
        .in1 (add_a_s),
        .in2 (add_b_s),
        .out (add_sum_s)
    );

`ifdef ADDER_ARB_SKID_EN
    logic                 pop_s;
    logic                 head_r;
    logic                 wr_idx_s;
    logic [BUS_WIDTH-1:0] sum_q_r [2];
    logic [ID_WIDTH-1:0]  id_q_r  [2];

    assign pop_s    = (state_r != EMPTY) && rsp_ready;
    assign accept_s = (state_r != FULL) || rsp_ready;
    // With one entry the tail is the slot after head; when empty or full it is head itself
    assign wr_idx_s = head_r ^ (state_r == MID);
`else
    logic [BUS_WIDTH-1:0] rsp_sum_r;
    logic [ID_WIDTH-1:0]  rsp_id_r;

    assign accept_s = (state_r == EMPTY) || rsp_ready;
`endif

    assign transfer_s = any_valid_s && accept_s;
    assign req_ready  = (accept_s && rst_n) ? grant_s : '0;
    assign rsp_valid  = (state_r != EMPTY);

    // Response occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Occupancy next-state from push (transfer) and pop
    always_comb begin
        state_next_s = state_r;
        case (state_r)
`ifdef ADDER_ARB_SKID_EN
            EMPTY: begin
                if (transfer_s) state_next_s = MID;
                else            state_next_s = EMPTY;
            end
            MID: begin
                if (transfer_s && !pop_s)      state_next_s = FULL;
                else if (!transfer_s && pop_s) state_next_s = EMPTY;
                else                           state_next_s = MID;
            end
            FULL: begin
                if (pop_s && !transfer_s) state_next_s = MID;
                else                      state_next_s = FULL;
            end
`else
            EMPTY: begin
                if (transfer_s) state_next_s = FULL;
                else            state_next_s = EMPTY;
            end
            FULL: begin
                if (transfer_s)     state_next_s = FULL;
                else if (rsp_ready) state_next_s = EMPTY;
                else                state_next_s = FULL;
            end
`endif
            default: state_next_s = EMPTY;
        endcase
    end

    // Round-robin pointer moves past the winner on each transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (transfer_s) begin
            if (winner_s == ID_WIDTH'(NUM_REQ - 1)) ptr_r <= '0;
            else                                   ptr_r <= winner_s + ID_WIDTH'(1);
        end
    end

`ifdef ADDER_ARB_SKID_EN
    // Two-slot response FIFO storage and head pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r     <= 1'b0;
            sum_q_r[0] <= '0;
            sum_q_r[1] <= '0;
            id_q_r[0]  <= '0;
            id_q_r[1]  <= '0;
        end else begin
            if (transfer_s) begin
                sum_q_r[wr_idx_s] <= add_sum_s;
                id_q_r[wr_idx_s]  <= winner_s;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
        end
    end

    assign rsp_sum = sum_q_r[head_r];
    assign rsp_id  = id_q_r[head_r];
`else
    // Single response register, reloaded on every transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum_r <= '0;
            rsp_id_r  <= '0;
        end else if (transfer_s) begin
            rsp_sum_r <= add_sum_s;
            rsp_id_r  <= winner_s;
        end
    end

    assign rsp_sum = rsp_sum_r;
    assign rsp_id  = rsp_id_r;
`endif

endmodule
